// File: rtl/superh16_pkg.sv
// superh16_pkg: shared types and constants for the SuperH16 memory-side slice.
//   PADDR_WIDTH / CACHE_LINE_SIZE / LINE_W / OFFSET_BITS : physical line geometry
//   l2_mem_req_t        : buffered L2 miss/writeback request {we, addr, wdata}
//   l2_resp_state_e     : memory responder FSM states
//   L2_MEM_PATTERN_HI   : upper word of the fill pattern for never-written lines
//   l2_mem_pattern()    : builds the fill pattern line for a given address
package superh16_pkg;

    localparam int PADDR_WIDTH     = 40;
    localparam int CACHE_LINE_SIZE = 64;
    localparam int LINE_W          = CACHE_LINE_SIZE * 8;
    localparam int OFFSET_BITS     = $clog2(CACHE_LINE_SIZE);

    localparam logic [31:0] L2_MEM_PATTERN_HI = 32'hA5A5_0000;

    typedef struct packed {
        logic                   we;
        logic [PADDR_WIDTH-1:0] addr;
        logic [LINE_W-1:0]      wdata;
    } l2_mem_req_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } l2_resp_state_e;

    // Each 64-bit word w carries {PATTERN_HI + w, line-aligned address low 32 bits},
    // so a bring-up trace identifies both the word lane and the line it came from.
    function automatic logic [LINE_W-1:0] l2_mem_pattern(input logic [PADDR_WIDTH-1:0] addr);
        logic [LINE_W-1:0] line;
        logic [31:0]       lo;
        lo = 32'(addr);
        lo[OFFSET_BITS-1:0] = '0;
        line = '0;
        for (int w = 0; w < LINE_W / 64; w++) begin
            line[w*64 +: 64] = {L2_MEM_PATTERN_HI + 32'(w), lo};
        end
        return line;
    endfunction

endpackage

// File: rtl/superh16_sync_fifo.sv
// superh16_sync_fifo: single-clock FIFO of arbitrary packed type T.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push, din  : write request and payload; accepted when not full, or when a pop
//                happens in the same cycle
//   pop        : remove head; ignored when empty
//   full/empty : occupancy flags
//   head       : current head entry (valid while !empty)
module superh16_sync_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  T     din,
    input  logic pop,
    output logic full,
    output logic empty,
    output T     head
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra MSB so full and empty are distinguishable.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    T            mem [DEPTH];

    logic do_pop;
    logic do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage is data only; occupancy is defined purely by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/superh16_l2_mem_responder.sv
// superh16_l2_mem_responder: memory-side stand-in for L3/DRAM below the private L2.
// Requests are buffered in a small FIFO, served in strict order from a direct-mapped
// line store after a fixed read or write latency, and answered with a one-cycle ack.
//   clk, rst_n    : clock, asynchronous active-low reset
//   mem_req       : request strobe (no backpressure), with mem_addr/mem_we/mem_wdata
//   mem_ack       : one-cycle response strobe; mem_rdata valid only with it (else 0)
//   busy          : FIFO non-empty or FSM not idle
//   err_overflow  : sticky, a request was dropped because the FIFO was full
//   rd_count      : completed reads, saturating
//   wr_count      : completed writes, saturating
module superh16_l2_mem_responder
    import superh16_pkg::*;
#(
    parameter int MEM_LINES      = 1024,
    parameter int RD_LATENCY     = 20,
    parameter int WR_LATENCY     = 8,
    parameter int REQ_FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mem_req,
    input  logic [PADDR_WIDTH-1:0] mem_addr,
    input  logic                   mem_we,
    input  logic [LINE_W-1:0]      mem_wdata,
    output logic                   mem_ack,
    output logic [LINE_W-1:0]      mem_rdata,
    output logic                   busy,
    output logic                   err_overflow,
    output logic [31:0]            rd_count,
    output logic [31:0]            wr_count
);

    localparam int IDX_W = $clog2(MEM_LINES);
    localparam int CNT_W = 16;

    // The pop cycle and the response cycle each account for one cycle of latency.
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LATENCY - 2);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LATENCY - 2);

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    l2_resp_state_e    state;
    logic [CNT_W-1:0]  cnt;
    l2_mem_req_t       push_req;
    l2_mem_req_t       head_req;
    l2_mem_req_t       cur_req;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic              drop;
    logic [IDX_W-1:0]  cur_idx;
    logic              access;
    logic [LINE_W-1:0] resp_data;

    logic [LINE_W-1:0]    store [MEM_LINES];
    logic [MEM_LINES-1:0] line_valid;

    assign push_req = '{we: mem_we, addr: mem_addr, wdata: mem_wdata};

    // The FSM takes a new request whenever it is idle or finishing a response.
    assign fifo_pop = !fifo_empty && ((state == IDLE) || (state == RESP));
    assign drop     = mem_req && fifo_full && !fifo_pop;
    assign busy     = !fifo_empty || (state != IDLE);

    superh16_sync_fifo #(
        .T     (l2_mem_req_t),
        .DEPTH (REQ_FIFO_DEPTH)
    ) u_req_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (mem_req),
        .din   (push_req),
        .pop   (fifo_pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head_req)
    );

    // Upper address bits are deliberately ignored: aliasing lines share an entry.
    assign cur_idx = cur_req.addr[OFFSET_BITS+IDX_W-1:OFFSET_BITS];
    assign access  = (state == WAIT) && (cnt == '0);

    always_comb begin
        resp_data = '0;
        if (!cur_req.we) begin
            resp_data = line_valid[cur_idx] ? store[cur_idx] : l2_mem_pattern(cur_req.addr);
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_pop) cur_req <= head_req;
    end

    always_ff @(posedge clk) begin
        if (access && cur_req.we) store[cur_idx] <= cur_req.wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            mem_ack      <= 1'b0;
            mem_rdata    <= '0;
            err_overflow <= 1'b0;
            rd_count     <= '0;
            wr_count     <= '0;
            line_valid   <= '0;
        end else begin
            mem_ack   <= 1'b0;
            mem_rdata <= '0;
            if (drop) err_overflow <= 1'b1;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        cnt   <= head_req.we ? WR_LOAD : RD_LOAD;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        mem_ack   <= 1'b1;
                        mem_rdata <= resp_data;
                        if (cur_req.we) begin
                            line_valid[cur_idx] <= 1'b1;
                            wr_count            <= sat_inc(wr_count);
                        end else begin
                            rd_count <= sat_inc(rd_count);
                        end
                        state <= RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (!fifo_empty) begin
                        cnt   <= head_req.we ? WR_LOAD : RD_LOAD;
                        state <= WAIT;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_superh16_l2_mem_responder.sv
module tb_superh16_l2_mem_responder;
    import superh16_pkg::*;

    localparam int RD_LAT = 20;
    localparam int WR_LAT = 8;

    logic                   clk;
    logic                   rst_n;
    logic                   mem_req;
    logic [PADDR_WIDTH-1:0] mem_addr;
    logic                   mem_we;
    logic [LINE_W-1:0]      mem_wdata;
    logic                   mem_ack;
    logic [LINE_W-1:0]      mem_rdata;
    logic                   busy;
    logic                   err_overflow;
    logic [31:0]            rd_count;
    logic [31:0]            wr_count;

    superh16_l2_mem_responder #(
        .MEM_LINES      (1024),
        .RD_LATENCY     (RD_LAT),
        .WR_LATENCY     (WR_LAT),
        .REQ_FIFO_DEPTH (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .busy         (busy),
        .err_overflow (err_overflow),
        .rd_count     (rd_count),
        .wr_count     (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [LINE_W-1:0] data;
        int                edge_no;
    } exp_t;

    exp_t              sbq[$];
    logic [LINE_W-1:0] model_mem [int];
    int                model_last = -100;
    int                tests = 0;
    int                fails = 0;
    logic [LINE_W-1:0] last_rdata = '0;

    task automatic check(input string name, input logic [LINE_W-1:0] act,
                         input logic [LINE_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [LINE_W-1:0] fill_pattern(input logic [PADDR_WIDTH-1:0] a);
        logic [LINE_W-1:0] l;
        logic [31:0]       base;
        base = a[31:0] & 32'hFFFF_FFC0;
        for (int w = 0; w < 8; w++) l[w*64 +: 64] = {32'hA5A5_0000 + w, base};
        return l;
    endfunction

    function automatic logic [LINE_W-1:0] mk_line(input logic [31:0] seed);
        logic [LINE_W-1:0] l;
        for (int i = 0; i < 16; i++) l[i*32 +: 32] = seed + i;
        return l;
    endfunction

    // Monitor: every ack pops the scoreboard; rdata must be zero between acks.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_ack) begin
                last_rdata = mem_rdata;
                if (sbq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_ack: got ack at cycle %0d, expected none", cyc);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("ack_data", mem_rdata, e.data);
                    check("ack_cycle", LINE_W'(cyc), LINE_W'(e.edge_no));
                end
            end else begin
                check("rdata_zero_no_ack", mem_rdata, '0);
            end
        end
    end

    // Drives one request for one edge; unless dropped, records its expected ack.
    task automatic issue(input logic we, input logic [PADDR_WIDTH-1:0] addr,
                         input logic [LINE_W-1:0] d, input bit drop);
        int t, s, idx;
        exp_t e;
        mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = d;
        @(negedge clk);
        t = cyc;
        mem_req = 1'b0;
        if (!drop) begin
            idx = int'((addr >> 6) & 40'h3FF);
            s = (t + 1 > model_last + 1) ? t + 1 : model_last + 1;
            e.edge_no = s + (we ? WR_LAT : RD_LAT) - 1;
            model_last = e.edge_no;
            if (we) begin
                model_mem[idx] = d;
                e.data = '0;
            end else begin
                e.data = model_mem.exists(idx) ? model_mem[idx] : fill_pattern(addr);
            end
            sbq.push_back(e);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d acks outstanding, expected 0", sbq.size());
            sbq.delete();
        end
        repeat (2) @(negedge clk);
        check("busy_idle", LINE_W'(busy), '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        sbq.delete();
        model_mem.delete();
        model_last = -100;
        repeat (2) @(negedge clk);
        check("rst_ack", LINE_W'(mem_ack), '0);
        check("rst_rdata", mem_rdata, '0);
        check("rst_busy", LINE_W'(busy), '0);
        check("rst_ovf", LINE_W'(err_overflow), '0);
        check("rst_rdcnt", LINE_W'(rd_count), '0);
        check("rst_wrcnt", LINE_W'(wr_count), '0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int target;
        int n;
        rst_n = 1'b0; mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
        do_reset();

        // Read of never-written line returns the fill pattern after RD_LAT.
        issue(1'b0, 40'h1000, '0, 1'b0);
        drain();
        check("t1_word0", LINE_W'(last_rdata[63:0]), LINE_W'(64'hA5A5_0000_0000_1000));
        check("t1_word1", LINE_W'(last_rdata[127:64]), LINE_W'(64'hA5A5_0001_0000_1000));
        check("t1_rdcnt", LINE_W'(rd_count), LINE_W'(1));

        // Write then read the same line.
        issue(1'b1, 40'h2040, mk_line(32'hD000_0000), 1'b0);
        issue(1'b0, 40'h2040, '0, 1'b0);
        drain();
        check("t2_data", last_rdata, mk_line(32'hD000_0000));
        check("t2_wrcnt", LINE_W'(wr_count), LINE_W'(1));
        check("t2_rdcnt", LINE_W'(rd_count), LINE_W'(2));

        // Alias: 0x10000 maps onto the same entry as 0x0.
        issue(1'b1, 40'h0, mk_line(32'hBEEF_0100), 1'b0);
        issue(1'b0, 40'h10000, '0, 1'b0);
        drain();
        check("t4_alias", last_rdata, mk_line(32'hBEEF_0100));

        // Overflow: one in service plus four buffered, the sixth is dropped.
        for (int i = 0; i < 5; i++) issue(1'b0, 40'h4000 + 40'(i * 64), '0, 1'b0);
        check("t3_ovf_before", LINE_W'(err_overflow), '0);
        issue(1'b0, 40'h4800, '0, 1'b1);
        check("t3_ovf_after", LINE_W'(err_overflow), LINE_W'(1));
        drain();
        check("t3_ovf_sticky", LINE_W'(err_overflow), LINE_W'(1));
        check("t3_rdcnt", LINE_W'(rd_count), LINE_W'(8));

        // Push into a full FIFO on the cycle the response state pops: accepted.
        do_reset();
        issue(1'b0, 40'h0100, '0, 1'b0);
        issue(1'b1, 40'h0140, mk_line(32'h4444_0000), 1'b0);
        issue(1'b0, 40'h0140, '0, 1'b0);
        issue(1'b0, 40'h0180, '0, 1'b0);
        issue(1'b1, 40'h01C0, mk_line(32'h5555_0000), 1'b0);
        target = sbq[0].edge_no;
        n = 0;
        while (cyc < target && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t6_align", LINE_W'(cyc), LINE_W'(target));
        issue(1'b0, 40'h01C0, '0, 1'b0);
        check("t6_ovf", LINE_W'(err_overflow), '0);
        drain();
        check("t6_last", last_rdata, mk_line(32'h5555_0000));
        check("t6_ovf_end", LINE_W'(err_overflow), '0);
        check("t6_wrcnt", LINE_W'(wr_count), LINE_W'(2));
        check("t6_rdcnt", LINE_W'(rd_count), LINE_W'(4));

        // Reset during WAIT discards the in-flight read and invalidates the store.
        issue(1'b1, 40'h3000, mk_line(32'h3333_0000), 1'b0);
        drain();
        issue(1'b0, 40'h5000, '0, 1'b0);
        repeat (3) @(negedge clk);
        do_reset();
        repeat (30) @(negedge clk);
        check("t5_busy", LINE_W'(busy), '0);
        check("t5_rdcnt", LINE_W'(rd_count), '0);
        issue(1'b0, 40'h3000, '0, 1'b0);
        drain();
        check("t5_pattern", last_rdata, fill_pattern(40'h3000));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
